// File: rtl/furv_pkg.sv
// ============================================================================
// furv_pkg : shared types and constants for the furv data-memory port
// Revision : 1.0 initial release
// ============================================================================
`default_nettype none

package furv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_t;

  localparam logic [31:0] FURV_MMIO_CYCLE  = 32'hFFFF_FFF0;
  localparam logic [31:0] FURV_MMIO_TOHOST = 32'hFFFF_FFF4;

  // byte-offset bits below the word index
  localparam int FURV_WORD_OFS_W = 2;

endpackage

`default_nettype wire

// File: rtl/furv_dmem_array.sv
// ============================================================================
// furv_dmem_array : single-port synchronous RAM, registered read data, no reset
// Revision : 1.0 initial release
// ============================================================================
`default_nettype none

module furv_dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] storage [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      storage[idx] <= wdata;
    end else begin
      rdata <= storage[idx];
    end
  end

endmodule

`default_nettype wire

// File: rtl/furv_dmem.sv
// ============================================================================
// furv_dmem : load/store responder for the furv core with programmable waits
// Optional MMIO (cycle counter, tohost) enabled by macro FURV_DMEM_MMIO_EN
// Revision : 1.0 initial release
// ============================================================================
`default_nettype none

module furv_dmem
  import furv_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic        mem,
  input  logic        mem_read,
  inout  wire  [31:0] data,
  output logic        ready,
  output logic        fault
`ifdef FURV_DMEM_MMIO_EN
  ,
  output logic [31:0] tohost,
  output logic        tohost_valid
`endif
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

  dmem_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      req_addr;
  logic             req_read;
  logic [31:0]      req_wdata;

  logic [31:0]      acc_addr;
  logic             acc_read;
  logic [31:0]      acc_wdata;
  logic             acc_err;
  logic             acc_mmio;
  logic             enter_resp;
  logic             ram_we;
  logic [31:0]      ram_rdata;
  logic [31:0]      rd_word;

`ifdef FURV_DMEM_MMIO_EN
  logic [31:0]      cycle_cnt;
`endif

  function automatic logic addr_err(input logic [31:0] a);
    logic err;
    err = (a[FURV_WORD_OFS_W-1:0] != '0) ||
          ((a >> FURV_WORD_OFS_W) >= 32'(DEPTH_WORDS));
`ifdef FURV_DMEM_MMIO_EN
    if (a == FURV_MMIO_CYCLE || a == FURV_MMIO_TOHOST) err = 1'b0;
`endif
    return err;
  endfunction

  // With zero wait states the access completes on the accept edge, so the
  // RAM and error logic must see the live inputs rather than the latch.
  assign acc_addr  = (state == ST_IDLE) ? addr     : req_addr;
  assign acc_read  = (state == ST_IDLE) ? mem_read : req_read;
  assign acc_wdata = (state == ST_IDLE) ? data     : req_wdata;
  assign acc_err   = addr_err(acc_addr);

`ifdef FURV_DMEM_MMIO_EN
  assign acc_mmio = (acc_addr == FURV_MMIO_CYCLE) || (acc_addr == FURV_MMIO_TOHOST);
`else
  assign acc_mmio = 1'b0;
`endif

  assign enter_resp = (state == ST_WAIT && cnt == '0) ||
                      (state == ST_IDLE && mem && (WAIT_STATES == 0));

  assign ram_we = rst_n && enter_resp && !acc_read && !acc_err && !acc_mmio;

  furv_dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .idx   (acc_addr[FURV_WORD_OFS_W +: IDX_W]),
    .wdata (acc_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      fault     <= 1'b0;
      req_addr  <= '0;
      req_read  <= 1'b0;
      req_wdata <= '0;
    end else begin
      fault <= enter_resp && acc_err;
      case (state)
        ST_IDLE: begin
          if (mem) begin
            req_addr  <= addr;
            req_read  <= mem_read;
            req_wdata <= data;
            if (WAIT_STATES > 0) begin
              state <= ST_WAIT;
              cnt   <= CNT_W'(WAIT_STATES - 1);
            end else begin
              state <= ST_RESP;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            state <= ST_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef FURV_DMEM_MMIO_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_cnt    <= '0;
      tohost       <= '0;
      tohost_valid <= 1'b0;
    end else begin
      cycle_cnt    <= cycle_cnt + 32'd1;
      tohost_valid <= enter_resp && !acc_read && (acc_addr == FURV_MMIO_TOHOST);
      if (enter_resp && !acc_read && (acc_addr == FURV_MMIO_TOHOST)) begin
        tohost <= acc_wdata;
      end
    end
  end
`endif

  always_comb begin
    rd_word = ram_rdata;
    if (fault) begin
      rd_word = '0;
    end
`ifdef FURV_DMEM_MMIO_EN
    else if (req_addr == FURV_MMIO_CYCLE) begin
      rd_word = cycle_cnt;
    end else if (req_addr == FURV_MMIO_TOHOST) begin
      rd_word = tohost;
    end
`endif
  end

  assign ready = (state == ST_RESP) || (state == ST_IDLE && !mem);
  assign data  = (state == ST_RESP && req_read) ? rd_word : 'z;

endmodule

`default_nettype wire

// File: tb/tb_furv_dmem.sv
// ============================================================================
// tb_furv_dmem : scoreboard bench over three furv_dmem configurations
// Revision : 1.0 initial release
// ============================================================================
`default_nettype none

module tb_furv_dmem;
  import furv_pkg::*;

  typedef struct {
    bit          rd;
    logic [31:0] data;
    logic        fault;
    int          lat;
  } exp_t;

  typedef struct {
    logic [31:0] data;
    logic        fault;
    int          lat;
    bit          hiz_ok;
    bit          post_ok;
    bit          timeout;
    logic        tv;
    int          cyc;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr [3];
  logic [31:0] wdat [3];
  logic [2:0]  mem, rd, drv, ready, fault, tv;
  wire  [31:0] d0, d1, d2;
  int          checks = 0;
  int          errors = 0;
  int          tb_cyc = 0;
  exp_t        exp_q[$];
  obs_t        obs_q[$];
  logic [31:0] model [64];

  always #5 clk = ~clk;
  always @(posedge clk) tb_cyc++;

  // undriven bus reads as all ones
  pullup pu0 (d0);
  pullup pu1 (d1);
  pullup pu2 (d2);
  assign d0 = drv[0] ? wdat[0] : 'z;
  assign d1 = drv[1] ? wdat[1] : 'z;
  assign d2 = drv[2] ? wdat[2] : 'z;

`ifdef FURV_DMEM_MMIO_EN
  logic [31:0] th [3];
`define TB_MMIO_PORTS(K) , .tohost(th[K]), .tohost_valid(tv[K])
`else
  assign tv = '0;
`define TB_MMIO_PORTS(K)
`endif

  furv_dmem #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .rst_n(rst_n), .addr(addr[0]), .mem(mem[0]), .mem_read(rd[0]),
    .data(d0), .ready(ready[0]), .fault(fault[0]) `TB_MMIO_PORTS(0));
  furv_dmem #(.DEPTH_WORDS(16), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst_n(rst_n), .addr(addr[1]), .mem(mem[1]), .mem_read(rd[1]),
    .data(d1), .ready(ready[1]), .fault(fault[1]) `TB_MMIO_PORTS(1));
  furv_dmem #(.DEPTH_WORDS(64), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst_n(rst_n), .addr(addr[2]), .mem(mem[2]), .mem_read(rd[2]),
    .data(d2), .ready(ready[2]), .fault(fault[2]) `TB_MMIO_PORTS(2));

  function automatic logic [31:0] bus(input int k);
    case (k)
      0:       return d0;
      1:       return d1;
      default: return d2;
    endcase
  endfunction

  task automatic expect_op(input bit r, input logic [31:0] d, input logic f, input int lat);
    exp_t e;
    e.rd = r; e.data = d; e.fault = f; e.lat = lat;
    exp_q.push_back(e);
  endtask

  // One complete core-side access; inputs are scrambled after the accept edge.
  task automatic run(input int k, input logic [31:0] a, input bit r, input logic [31:0] wd);
    obs_t o;
    int   n;
    o.data = '0; o.fault = 1'b0; o.lat = 0; o.hiz_ok = 1'b1; o.post_ok = 1'b0;
    o.timeout = 1'b0; o.tv = 1'b0; o.cyc = 0;
    @(negedge clk);
    addr[k] = a; mem[k] = 1'b1; rd[k] = r; wdat[k] = wd; drv[k] = !r;
    n = 0;
    forever begin
      #1;
      if (ready[k]) break;
      if (r && bus(k) !== 32'hFFFF_FFFF) o.hiz_ok = 1'b0;
      n++;
      if (n > 40) begin
        o.timeout = 1'b1;
        break;
      end
      @(negedge clk);
      addr[k] = $urandom; wdat[k] = $urandom; rd[k] = 1'($urandom);
    end
    o.lat = n; o.data = bus(k); o.fault = fault[k]; o.tv = tv[k]; o.cyc = tb_cyc;
    mem[k] = 1'b0; drv[k] = 1'b0;
    @(posedge clk); #1;
    o.post_ok = (ready[k] === 1'b1) && (fault[k] === 1'b0) && (bus(k) === 32'hFFFF_FFFF);
    obs_q.push_back(o);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ready[k] !== 1'b1 || fault[k] !== 1'b0 || bus(k) !== 32'hFFFF_FFFF) begin
        errors++;
        $display("FAIL reset[%0d]: ready=%b fault=%b data=%h, expected ready=1 fault=0 data=ffffffff",
                 k, ready[k], fault[k], bus(k));
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_store_load;
    exp_t e; obs_t o;
    expect_op(0, 'x, 0, 2); run(0, 32'h10, 0, 32'hDEADBEEF);
    expect_op(1, 32'hDEADBEEF, 0, 2); run(0, 32'h10, 1, 0);
    expect_op(0, 'x, 0, 2); run(0, 32'h14, 0, 32'h0000_0000);
    expect_op(1, 32'h0000_0000, 0, 2); run(0, 32'h14, 1, 0);
    expect_op(1, 32'hDEADBEEF, 0, 2); run(0, 32'h10, 1, 0);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.timeout || o.lat !== e.lat || o.fault !== e.fault || !o.post_ok ||
          (e.rd && (o.data !== e.data || !o.hiz_ok))) begin
        errors++;
        $display("FAIL store_load: data=%h fault=%b lat=%0d post=%0b hiz=%0b, expected data=%h fault=%b lat=%0d",
                 o.data, o.fault, o.lat, o.post_ok, o.hiz_ok, e.data, e.fault, e.lat);
      end
    end
  endtask

  task automatic test_wait_states;
    exp_t e; obs_t o;
    expect_op(0, 'x, 0, 4); run(1, 32'h8, 0, 32'hA5A5_0001);
    expect_op(1, 32'hA5A5_0001, 0, 4); run(1, 32'h8, 1, 0);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.timeout || o.lat !== e.lat || o.fault !== e.fault || !o.post_ok ||
          (e.rd && (o.data !== e.data || !o.hiz_ok))) begin
        errors++;
        $display("FAIL wait_states: data=%h fault=%b lat=%0d post=%0b hiz=%0b, expected data=%h fault=%b lat=%0d",
                 o.data, o.fault, o.lat, o.post_ok, o.hiz_ok, e.data, e.fault, e.lat);
      end
    end
  endtask

  task automatic test_misaligned;
    exp_t e; obs_t o;
    expect_op(0, 'x, 1, 2); run(0, 32'h12, 0, 32'h1);
    expect_op(1, 32'hDEADBEEF, 0, 2); run(0, 32'h10, 1, 0);
    expect_op(1, 32'h0, 1, 2); run(0, 32'h11, 1, 0);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.timeout || o.lat !== e.lat || o.fault !== e.fault || !o.post_ok ||
          (e.rd && (o.data !== e.data || !o.hiz_ok))) begin
        errors++;
        $display("FAIL misaligned: data=%h fault=%b lat=%0d post=%0b hiz=%0b, expected data=%h fault=%b lat=%0d",
                 o.data, o.fault, o.lat, o.post_ok, o.hiz_ok, e.data, e.fault, e.lat);
      end
    end
  endtask

  task automatic test_range;
    exp_t e; obs_t o;
    expect_op(0, 'x, 0, 4); run(1, 32'h00, 0, 32'h1234_5678);
    expect_op(0, 'x, 0, 4); run(1, 32'h3C, 0, 32'hCAFE_003C);
    expect_op(0, 'x, 1, 4); run(1, 32'h40, 0, 32'h0000_0BAD);
    expect_op(1, 32'h0, 1, 4); run(1, 32'h40, 1, 0);
    expect_op(1, 32'hCAFE_003C, 0, 4); run(1, 32'h3C, 1, 0);
    expect_op(1, 32'h1234_5678, 0, 4); run(1, 32'h00, 1, 0);
`ifndef FURV_DMEM_MMIO_EN
    expect_op(1, 32'h0, 1, 4); run(1, FURV_MMIO_CYCLE, 1, 0);
    expect_op(0, 'x, 1, 4); run(1, FURV_MMIO_TOHOST, 0, 32'h1);
`endif
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.timeout || o.lat !== e.lat || o.fault !== e.fault || !o.post_ok ||
          (e.rd && (o.data !== e.data || !o.hiz_ok))) begin
        errors++;
        $display("FAIL range: data=%h fault=%b lat=%0d post=%0b hiz=%0b, expected data=%h fault=%b lat=%0d",
                 o.data, o.fault, o.lat, o.post_ok, o.hiz_ok, e.data, e.fault, e.lat);
      end
    end
  endtask

  task automatic test_reset_in_wait;
    exp_t e; obs_t o;
    expect_op(0, 'x, 0, 4); run(1, 32'h20, 0, 32'h1111_1111);
    @(negedge clk);
    addr[1] = 32'h20; mem[1] = 1'b1; rd[1] = 1'b0; wdat[1] = 32'h55; drv[1] = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (ready[1] !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait_busy: ready=%b, expected 0", ready[1]);
    end
    rst_n = 1'b0; mem[1] = 1'b0; drv[1] = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (ready[1] !== 1'b1 || fault[1] !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait_idle: ready=%b fault=%b, expected ready=1 fault=0", ready[1], fault[1]);
    end
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    expect_op(1, 32'h1111_1111, 0, 4); run(1, 32'h20, 1, 0);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.timeout || o.lat !== e.lat || o.fault !== e.fault || !o.post_ok ||
          (e.rd && (o.data !== e.data || !o.hiz_ok))) begin
        errors++;
        $display("FAIL rst_wait: data=%h fault=%b lat=%0d post=%0b hiz=%0b, expected data=%h fault=%b lat=%0d",
                 o.data, o.fault, o.lat, o.post_ok, o.hiz_ok, e.data, e.fault, e.lat);
      end
    end
  endtask

  task automatic test_random_ws0;
    exp_t        e; obs_t o;
    int          w, mis;
    bit          r, err;
    logic [31:0] v;
    for (int i = 0; i < 64; i++) begin
      model[i] = $urandom & 32'h7FFF_FFFE;
      expect_op(0, 'x, 0, 1); run(2, 32'(i * 4), 0, model[i]);
    end
    for (int i = 0; i < 40; i++) begin
      w   = $urandom_range(0, 71);
      mis = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
      r   = 1'($urandom_range(0, 1));
      v   = $urandom & 32'h7FFF_FFFF;
      err = (mis != 0) || (w >= 64);
      if (!r && !err) model[w] = v;
      expect_op(r, err ? 32'h0 : model[w % 64], err, 1);
      run(2, 32'(w * 4 + mis), r, v);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o.timeout || o.lat !== e.lat || o.fault !== e.fault || !o.post_ok ||
          (e.rd && (o.data !== e.data || !o.hiz_ok))) begin
        errors++;
        $display("FAIL random_ws0: data=%h fault=%b lat=%0d post=%0b hiz=%0b, expected data=%h fault=%b lat=%0d",
                 o.data, o.fault, o.lat, o.post_ok, o.hiz_ok, e.data, e.fault, e.lat);
      end
    end
  endtask

`ifdef FURV_DMEM_MMIO_EN
  task automatic test_mmio;
    obs_t o, o2;
    run(0, FURV_MMIO_TOHOST, 0, 32'h1);
    o = obs_q.pop_front();
    checks++;
    if (o.timeout || o.fault !== 1'b0 || o.tv !== 1'b1 || tv[0] !== 1'b0 || th[0] !== 32'h1) begin
      errors++;
      $display("FAIL mmio_tohost: fault=%b tv_resp=%b tv_after=%b tohost=%h, expected 0 1 0 00000001",
               o.fault, o.tv, tv[0], th[0]);
    end
    run(0, FURV_MMIO_CYCLE, 1, 0);
    run(0, FURV_MMIO_CYCLE, 1, 0);
    o = obs_q.pop_front(); o2 = obs_q.pop_front();
    checks++;
    if (o.fault !== 1'b0 || o2.fault !== 1'b0 || (o2.data - o.data) !== 32'(o2.cyc - o.cyc)) begin
      errors++;
      $display("FAIL mmio_cycle: delta=%0d faults=%b%b, expected delta=%0d faults=00",
               o2.data - o.data, o.fault, o2.fault, o2.cyc - o.cyc);
    end
    run(0, FURV_MMIO_CYCLE, 0, 32'h5);
    run(0, FURV_MMIO_TOHOST, 1, 0);
    o = obs_q.pop_front(); o2 = obs_q.pop_front();
    checks++;
    if (o.fault !== 1'b0 || o.tv !== 1'b0 || o2.data !== 32'h1 || o2.fault !== 1'b0) begin
      errors++;
      $display("FAIL mmio_misc: store_fault=%b store_tv=%b rd_tohost=%h rd_fault=%b, expected 0 0 00000001 0",
               o.fault, o.tv, o2.data, o2.fault);
    end
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; mem = '0; rd = '0; drv = '0;
    for (int k = 0; k < 3; k++) begin
      addr[k] = '0; wdat[k] = '0;
    end
    test_reset();
    test_store_load();
    test_wait_states();
    test_misaligned();
    test_range();
    test_reset_in_wait();
    test_random_ws0();
`ifdef FURV_DMEM_MMIO_EN
    test_mmio();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
